spram_be_init: RTL and testbench

//  Parametrised single-port SRAM with a shared address bus (half duplex: one read OR one write per cycle).

---
 rtl/spram_pkg.sv | 23 ++
 rtl/spram_clr_ctrl.sv | 72 +++++++
 rtl/spram_be_init.sv | 164 ++++++++++++++++
 tb/tb_spram_be_init.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared definitions for the byte-enable scratchpad RAM:
// read-during-write modes, clear FSM states and the lane merge helper.
package spram_pkg;

    localparam int RD_NO_CHANGE   = 0;
    localparam int RD_WRITE_FIRST = 1;
    localparam int RD_READ_FIRST  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // One byte lane of a partial write: take the new byte when enabled.
    function automatic logic [7:0] lane_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       sel
    );
        return sel ? new_b : old_b;
    endfunction

endpackage

// File: rtl/spram_clr_ctrl.sv
// Zero-fill sweep controller: walks every word once, holding busy high
// for exactly DEPTH cycles; restarts on clr or on reset release.
module spram_clr_ctrl
    import spram_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int INIT_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam clr_state_t RST_STATE =
        (INIT_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    clr_state_t        state;
    clr_state_t        state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;

    // State and sweep counter; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state, counter advance and sweep strobe.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy     = 1'b0;
        sweep_we = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (clr) begin
                    state_nx = ST_CLEAR;
                    cnt_nx   = '0;
                end
            end
            ST_CLEAR: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                if (clr) begin
                    cnt_nx = '0;
                end else if (cnt == LAST) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign sweep_addr = cnt;

endmodule

// File: rtl/spram_be_init.sv
// Single-port scratchpad RAM with byte enables, read-during-write modes,
// optional output register and a hardware zero-fill engine.
module spram_be_init
    import spram_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int RD_MODE     = 0,
    parameter int OUT_REG     = 0,
    parameter int INIT_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  r_w,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     d_in,
    input  logic                  clr,
    output logic [DATA_W-1:0]     d_out,
    output logic                  d_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;

    logic              acc;
    logic              acc_rd;
    logic              acc_wr;
    logic              in_range;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              s_valid;
    logic              s_err;
    logic [DATA_W-1:0] s_word;

    logic              o_valid;
    logic              o_err;
    logic [DATA_W-1:0] o_word;

    spram_clr_ctrl #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .INIT_ON_RST (INIT_ON_RST)
    ) u_clr (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // A clr pulse in the same cycle also swallows the user request.
    assign acc      = en && !busy && !clr;
    assign acc_rd   = acc && !r_w;
    assign acc_wr   = acc && r_w;
    assign in_range = {1'b0, addr} < DEPTH_X;

    // Current word at the user address and its byte-lane merge.
    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem[addr];
        end
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            merged[8*i +: 8] = lane_merge(old_word[8*i +: 8],
                                          d_in[8*i +: 8], be[i]);
        end
    end

    // Single array port: sweep has priority, user writes otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr;
        mem_wdata = merged;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_addr;
            mem_wdata = '0;
        end else if (acc_wr && in_range) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; contents survive reset until the sweep clears them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // First-stage response: what the port returns for this access.
    // Out-of-range accesses always return a zero word.
    always_comb begin
        s_err   = acc && !in_range;
        s_valid = acc_rd || (acc_wr && RD_MODE != RD_NO_CHANGE);
        s_word  = old_word;
        if (!in_range) begin
            s_word = '0;
        end else if (acc_wr && RD_MODE == RD_WRITE_FIRST) begin
            s_word = merged;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              p_valid;
            logic              p_err;
            logic [DATA_W-1:0] p_word;

            // Extra latency stage; reset flushes anything in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_valid <= 1'b0;
                    p_err   <= 1'b0;
                    p_word  <= '0;
                end else begin
                    p_valid <= s_valid;
                    p_err   <= s_err;
                    p_word  <= s_word;
                end
            end

            assign o_valid = p_valid;
            assign o_err   = p_err;
            assign o_word  = p_word;
        end else begin : g_direct
            assign o_valid = s_valid;
            assign o_err   = s_err;
            assign o_word  = s_word;
        end
    endgenerate

    // Output register: d_out only moves when a new word is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out   <= '0;
            d_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            d_valid <= o_valid;
            err     <= o_err;
            if (o_valid) begin
                d_out <= o_word;
            end
        end
    end

endmodule

// File: tb/tb_spram_be_init.sv
// Scoreboard bench: four RAM configurations share one random stimulus
// stream and are checked against a word-level memory model.
module tb_spram_be_init;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        r_w = 1'b0;
    logic [4:0]  addr = '0;
    logic [1:0]  be = '0;
    logic [15:0] d_in = '0;
    logic        clr = 1'b0;

    logic [15:0] d_out [4];
    logic        d_valid [4];
    logic        busy [4];
    logic        err [4];

    always #5 clk = ~clk;

    spram_be_init #(.DEPTH(32), .RD_MODE(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .r_w(r_w), .addr(addr), .be(be),
        .d_in(d_in), .clr(clr), .d_out(d_out[0]), .d_valid(d_valid[0]),
        .busy(busy[0]), .err(err[0]));

    spram_be_init #(.DEPTH(32), .RD_MODE(1), .OUT_REG(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .r_w(r_w), .addr(addr), .be(be),
        .d_in(d_in), .clr(clr), .d_out(d_out[1]), .d_valid(d_valid[1]),
        .busy(busy[1]), .err(err[1]));

    spram_be_init #(.DEPTH(32), .RD_MODE(2), .OUT_REG(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .r_w(r_w), .addr(addr), .be(be),
        .d_in(d_in), .clr(clr), .d_out(d_out[2]), .d_valid(d_valid[2]),
        .busy(busy[2]), .err(err[2]));

    spram_be_init #(.DEPTH(20), .RD_MODE(2), .OUT_REG(1)) u3 (
        .clk(clk), .rst(rst), .en(en), .r_w(r_w), .addr(addr), .be(be),
        .d_in(d_in), .clr(clr), .d_out(d_out[3]), .d_valid(d_valid[3]),
        .busy(busy[3]), .err(err[3]));

    function automatic int dep_of(input int k);
        return (k == 3) ? 20 : 32;
    endfunction

    function automatic int mode_of(input int k);
        return (k == 3) ? 2 : k;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    typedef struct {
        int          due;
        bit          vis;
        bit          er;
        logic [15:0] data;
        bit          cancel;
    } ent_t;

    ent_t        sb [4][8192];
    int          wr_p [4];
    int          rd_p [4];
    logic [15:0] mm [4][32];
    int          busy_left [4];
    logic [15:0] last [4];
    int          cyc = 0;
    bit          done = 1'b0;
    int          checks = 0;
    int          failures = 0;

    initial begin
        for (int k = 0; k < 4; k++) begin
            wr_p[k] = 0;
            rd_p[k] = 0;
            busy_left[k] = dep_of(k);
            last[k] = '0;
        end
    end

    // Model of one clock edge for every configuration.
    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            int          a;
            bit          inr;
            logic [15:0] old_w;
            logic [15:0] new_w;
            ent_t        e;
            a = int'(addr);
            if (rst || clr) begin
                busy_left[k] = dep_of(k);
                for (int j = 0; j < 32; j++) mm[k][j] = '0;
            end else if (busy_left[k] > 0) begin
                busy_left[k]--;
            end else if (en) begin
                inr   = a < dep_of(k);
                old_w = inr ? mm[k][a] : 16'h0000;
                new_w = old_w;
                if (be[0]) new_w[7:0] = d_in[7:0];
                if (be[1]) new_w[15:8] = d_in[15:8];
                e.due    = cyc + lat_of(k) - 1;
                e.er     = !inr;
                e.cancel = 1'b0;
                if (r_w) begin
                    if (inr) mm[k][a] = new_w;
                    e.vis  = mode_of(k) != 0;
                    e.data = !inr ? 16'h0000 :
                             (mode_of(k) == 1) ? new_w : old_w;
                end else begin
                    e.vis  = 1'b1;
                    e.data = old_w;
                end
                if (e.vis || e.er) begin
                    sb[k][wr_p[k]] = e;
                    wr_p[k]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic drv(input bit e, input bit rw, input int a,
                       input int b, input int d, input bit c);
        en   = e;
        r_w  = rw;
        addr = 5'(a);
        be   = 2'(b);
        d_in = 16'(d);
        clr  = c;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drv(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d, input int b);
        drv(1, 1, a, b, d, 0);
    endtask

    task automatic rd(input int a);
        drv(1, 0, a, 0, 0, 0);
    endtask

    // Asynchronous reset: outputs clear at once, pending words are lost.
    task automatic do_rst(input int n);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            busy_left[k] = dep_of(k);
            for (int i = (wr_p[k] > 8 ? wr_p[k] - 8 : 0); i < wr_p[k]; i++)
                if (sb[k][i].due >= cyc) sb[k][i].cancel = 1'b1;
        end
        idle(n);
        rst = 1'b0;
    endtask

    task automatic chk(input string nm, input int k,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s u%0d cyc=%0d actual=%h required=%h",
                     nm, k, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is due.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            bit          hit;
            bit          ev;
            bit          ee;
            while (rd_p[k] < wr_p[k] && sb[k][rd_p[k]].cancel) rd_p[k]++;
            hit = rd_p[k] < wr_p[k] && sb[k][rd_p[k]].due == cyc;
            ev  = hit && sb[k][rd_p[k]].vis;
            ee  = hit && sb[k][rd_p[k]].er;
            if (rst) last[k] = '0;
            if (ev) last[k] = sb[k][rd_p[k]].data;
            chk("d_valid", k, 16'(d_valid[k]), 16'(ev));
            chk("err", k, 16'(err[k]), 16'(ee));
            chk("d_out", k, d_out[k], last[k]);
            chk("busy", k, 16'(busy[k]), 16'(busy_left[k] > 0));
            if (hit) rd_p[k]++;
        end
        if (done) begin
            for (int k = 0; k < 4; k++) begin
                int pend;
                pend = 0;
                for (int i = rd_p[k]; i < wr_p[k]; i++)
                    if (!sb[k][i].cancel) pend++;
                chk("drain", k, 16'(pend), 16'h0000);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Stimulus: directed scenarios followed by a random stream.
    initial begin
        do_rst(3);
        idle(34);
        for (int a = 0; a < 32; a++) rd(a);

        wr(7, 16'hCC33, 3);
        wr(2, 16'h5577, 3);
        wr(14, 16'h1464, 3);
        wr(6, 16'h1144, 3);
        rd(7);
        rd(14);
        rd(6);
        idle(2);

        wr(7, 16'hCC33, 3);
        wr(7, 16'hAB00, 2);
        rd(7);
        wr(9, 16'hFFFF, 0);
        rd(9);
        idle(2);

        wr(3, 16'h2222, 3);
        wr(3, 16'h1111, 3);
        rd(3);
        idle(2);

        drv(1, 0, 7, 0, 0, 1);
        for (int i = 0; i < 10; i++) rd(7);
        idle(25);
        rd(7);
        idle(2);

        wr(7, 16'h7E7E, 3);
        drv(0, 0, 0, 0, 0, 1);
        idle(10);
        do_rst(2);
        for (int i = 0; i < 33; i++) rd(7);
        idle(2);

        wr(25, 16'hBEEF, 3);
        rd(25);
        wr(19, 16'h1234, 3);
        rd(19);
        drv(1, 0, 25, 0, 0, 0);
        do_rst(1);
        idle(34);
        rd(25);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                do_rst(2);
            end else begin
                drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 65535)), r < 10);
            end
        end
        idle(4);
        done = 1'b1;
    end

endmodule
